// File: rtl/msg_pkg.sv
// Shared constants, FSM state type and field layout for the serial-link
// message assembler.
package msg_pkg;

  localparam int MSG_W     = 168;
  localparam int MSG_BYTES = 21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Field bit positions within the assembled 168-bit message.
  localparam int HDR_HI   = 167;
  localparam int HDR_LO   = 144;
  localparam int F1_HI    = 143;
  localparam int F1_LO    = 112;
  localparam int PRICE_HI = 111;
  localparam int PRICE_LO = 80;
  localparam int F3_HI    = 79;
  localparam int F3_LO    = 48;
  localparam int SIDE_HI  = 47;
  localparam int SIDE_LO  = 40;
  localparam int ID_HI    = 39;
  localparam int ID_LO    = 8;
  localparam int CKSUM_HI = 7;
  localparam int CKSUM_LO = 0;

endpackage

// File: rtl/msg_timeout.sv
// Idle-cycle counter used to abandon a stalled partial message. Counts while
// en is high, clears on clr, saturates, and flags expired in the cycle whose
// idle clock would bring the count to TIMEOUT_CYC.
module msg_timeout
  import msg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT      = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] LIMIT_LESS = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // Idle count register: cleared by any transfer or outside COLLECT, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count >= LIMIT_LESS);

endmodule

// File: rtl/msg_assembler.sv
// Assembles 21-byte checksummed messages from a byte stream into a single
// 168-bit output slot with valid/ready handshakes on both sides. A message
// that arrives while the slot is still occupied is parked (HOLD) and the
// byte stream is stalled until the slot drains.
module msg_assembler
  import msg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [MSG_W-1:0] msg,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic             err_pulse
);

  localparam logic [4:0] LAST_CNT = 5'(MSG_BYTES - 1);
  localparam logic [4:0] FULL_CNT = 5'(MSG_BYTES);

  state_t           state, state_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic [7:0]       xacc, xacc_nxt;
  logic [MSG_W-1:0] sreg;
  logic [MSG_W-1:0] load_data;
  logic             xfer, slot_free, cksum_ok;
  logic             load_direct, load_hold, err_nxt;
  logic             tmo_clr, tmo_en, expired;

  assign byte_ready = (state != HOLD);
  assign xfer       = byte_valid && byte_ready;
  assign slot_free  = !msg_valid || msg_ready;
  // Running XOR covers bytes 1-20 when byte 21 arrives, so it must equal the checksum byte.
  assign cksum_ok   = (xacc == byte_in);
  assign tmo_en     = (state == COLLECT) && !xfer;
  assign tmo_clr    = (state != COLLECT) || xfer;
  // A parked message is already complete in sreg; otherwise byte 21 completes it this cycle.
  assign load_data  = load_hold ? sreg : {sreg[MSG_W-9:0], byte_in};

  msg_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(expired)
  );

  // Next-state, byte count and running XOR; a transfer outranks a timeout in the same cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    xacc_nxt    = xacc;
    load_direct = 1'b0;
    load_hold   = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = COLLECT;
          cnt_nxt   = 5'd1;
          xacc_nxt  = byte_in;
        end
      end
      COLLECT: begin
        if (xfer) begin
          if (cnt == LAST_CNT) begin
            cnt_nxt  = 5'd0;
            xacc_nxt = 8'd0;
            if (!cksum_ok) begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end else if (slot_free) begin
              load_direct = 1'b1;
              state_nxt   = IDLE;
            end else begin
              cnt_nxt   = FULL_CNT;
              state_nxt = HOLD;
            end
          end else begin
            cnt_nxt  = cnt + 5'd1;
            xacc_nxt = xacc ^ byte_in;
          end
        end else if (expired) begin
          state_nxt = IDLE;
          cnt_nxt   = 5'd0;
          xacc_nxt  = 8'd0;
          err_nxt   = 1'b1;
        end
      end
      HOLD: begin
        if (slot_free) begin
          load_hold = 1'b1;
          cnt_nxt   = 5'd0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 5'd0;
        xacc_nxt  = 8'd0;
      end
    endcase
  end

  // Control state, output slot and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      xacc      <= 8'd0;
      err_pulse <= 1'b0;
      msg_valid <= 1'b0;
      msg       <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      xacc      <= xacc_nxt;
      err_pulse <= err_nxt;
      if (load_direct || load_hold) begin
        msg_valid <= 1'b1;
        msg       <= load_data;
      end else if (msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

  // Byte shift register; after 21 transfers the first byte sits in the top octet.
  always_ff @(posedge clk) begin
    if (xfer) begin
      sreg <= {sreg[MSG_W-9:0], byte_in};
    end
  end

endmodule

// File: tb/tb_msg_assembler.sv
// Self-checking bench for msg_assembler: directed scenarios plus a randomized
// run scored against a message-level reference (good iff XOR of all 21 bytes is 0).
module tb_msg_assembler;
  import msg_pkg::*;

  localparam int TMO = 16;
  localparam logic [167:0] MSG_A = 168'h000000_00000001_00000060_00000000_00_00000000_61;
  localparam logic [167:0] MSG_B = 168'h000000_00000001_00000068_00000000_01_00000001_69;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic [167:0] msg;
  logic         msg_valid;
  logic         msg_ready;
  logic         err_pulse;

  int checks = 0;
  int errors = 0;
  logic [167:0] got_q[$];
  int err_seen = 0;

  always #5 clk = ~clk;

  msg_assembler #(.TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .msg       (msg),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .err_pulse (err_pulse)
  );

  // Observe consumed messages and error pulses; values at negedge are those seen by the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      if (msg_valid && msg_ready) got_q.push_back(msg);
      if (err_pulse) err_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xor_all(input logic [167:0] m);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < 21; i++) x ^= m[8*i +: 8];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait (bounded) until it is accepted; returns at posedge+1 of the transfer.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    int budget;
    done = 0;
    budget = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!done && budget < 200) begin
      @(negedge clk);
      if (byte_ready) done = 1;
      tick();
      budget++;
    end
    byte_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_byte: byte_ready stayed %b, required 1 within 200 cycles", byte_ready);
    end
  endtask

  task automatic send_msg(input logic [167:0] m, input int gap_max);
    for (int i = 0; i < 21; i++) begin
      send_byte(m[167-8*i -: 8]);
      if (gap_max > 0 && i < 20) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'd0;
    msg_ready = 1'b0;
    repeat (3) tick();
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL reset_byte_ready: got %b, expected 1", byte_ready); end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL reset_msg_valid: got %b, expected 0", msg_valid); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b, expected 0", err_pulse); end
    checks++; if (msg !== '0) begin errors++; $display("FAIL reset_msg: got %h, expected 0", msg); end
    rst = 1'b1;
    tick();
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL post_reset_byte_ready: got %b, expected 1", byte_ready); end
  endtask

  task automatic test_msg_a();
    int e0;
    e0 = err_seen;
    got_q.delete();
    msg_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_byte(MSG_A[167-8*i -: 8]);
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL a_early_valid: got %b, expected 0", msg_valid); end
    send_byte(MSG_A[7:0]);
    checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL a_latency: msg_valid %b, expected 1", msg_valid); end
    checks++; if (msg !== MSG_A) begin errors++; $display("FAIL a_contents: got %h, expected %h", msg, MSG_A); end
    tick();
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL a_one_cycle: msg_valid %b, expected 0", msg_valid); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL a_count: got %0d, expected 1", got_q.size()); end
    checks++; if (err_seen !== e0) begin errors++; $display("FAIL a_no_err: got %0d pulses, expected 0", err_seen - e0); end
  endtask

  task automatic test_bad_cksum();
    logic [167:0] bad;
    bad = {MSG_A[167:8], 8'h62};
    msg_ready = 1'b1;
    send_msg(bad, 0);
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL bad_err: got %b, expected 1", err_pulse); end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL bad_valid: got %b, expected 0", msg_valid); end
    tick();
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL bad_err_width: got %b, expected 0", err_pulse); end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL bad_valid_late: got %b, expected 0", msg_valid); end
  endtask

  task automatic test_back_to_back();
    msg_ready = 1'b0;
    send_msg(MSG_A, 0);
    checks++; if (msg !== MSG_A || msg_valid !== 1'b1) begin errors++; $display("FAIL bb_a_loaded: got %h/%b, expected %h/1", msg, msg_valid, MSG_A); end
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL bb_ready_after_a: got %b, expected 1", byte_ready); end
    send_msg(MSG_B, 0);
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL bb_hold_ready: got %b, expected 0", byte_ready); end
    checks++; if (msg !== MSG_A || msg_valid !== 1'b1) begin errors++; $display("FAIL bb_a_stable: got %h/%b, expected %h/1", msg, msg_valid, MSG_A); end
    repeat (3) tick();
    checks++; if (msg !== MSG_A || byte_ready !== 1'b0) begin errors++; $display("FAIL bb_a_held: got %h ready %b, expected %h ready 0", msg, byte_ready, MSG_A); end
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    checks++; if (msg !== MSG_B || msg_valid !== 1'b1) begin errors++; $display("FAIL bb_b_loaded: got %h/%b, expected %h/1", msg, msg_valid, MSG_B); end
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL bb_ready_back: got %b, expected 1", byte_ready); end
    msg_ready = 1'b1;
    tick();
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL bb_drained: got %b, expected 0", msg_valid); end
  endtask

  task automatic test_timeout();
    bit early, seen;
    early = 0;
    seen = 0;
    msg_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(MSG_A[167-8*i -: 8]);
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      if (err_pulse) early = 1;
    end
    checks++; if (early) begin errors++; $display("FAIL tmo_early: err_pulse 1 before %0d idle cycles, expected 0", TMO); end
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      if (err_pulse) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL tmo_err: err_pulse 0, expected 1 after %0d idle cycles", TMO); end
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready: got %b, expected 1", byte_ready); end
    send_msg(MSG_A, 0);
    checks++; if (msg !== MSG_A || msg_valid !== 1'b1) begin errors++; $display("FAIL tmo_next_msg: got %h/%b, expected %h/1", msg, msg_valid, MSG_A); end
    tick();
  endtask

  task automatic test_reset_mid();
    msg_ready = 1'b0;
    send_msg(MSG_A, 0);
    for (int i = 0; i < 15; i++) send_byte(MSG_B[167-8*i -: 8]);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (msg_valid !== 1'b0 || msg !== '0) begin errors++; $display("FAIL rstmid_async: got %h/%b, expected 0/0", msg, msg_valid); end
    checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, expected 1", byte_ready); end
    tick();
    rst = 1'b1;
    tick();
    got_q.delete();
    msg_ready = 1'b1;
    send_msg(MSG_A, 0);
    checks++; if (msg !== MSG_A || msg_valid !== 1'b1) begin errors++; $display("FAIL rstmid_msg: got %h/%b, expected %h/1", msg, msg_valid, MSG_A); end
    tick();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rstmid_count: got %0d, expected 1", got_q.size()); end
  endtask

  task automatic test_random();
    logic [167:0] exp_q[$];
    int nbad, e0, n;
    bit done;
    nbad = 0;
    done = 0;
    e0 = err_seen;
    got_q.delete();
    fork
      begin
        for (int m = 0; m < 30; m++) begin
          logic [167:0] mm;
          logic [159:0] body;
          body = {$urandom, $urandom, $urandom, $urandom, $urandom};
          mm = {body, 8'd0};
          mm[7:0] = xor_all(mm);
          if ($urandom_range(0, 3) == 0) mm[7:0] = mm[7:0] ^ 8'($urandom_range(1, 255));
          if (xor_all(mm) == 8'd0) exp_q.push_back(mm);
          else nbad++;
          send_msg(mm, (m % 2 == 1) ? 3 : 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          msg_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    msg_ready = 1'b1;
    repeat (5) tick();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d, expected %0d", got_q.size(), exp_q.size()); end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_msg%0d: got %h, expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_seen - e0 !== nbad) begin errors++; $display("FAIL rand_errs: got %0d, expected %0d", err_seen - e0, nbad); end
  endtask

  initial begin
    test_reset();
    test_msg_a();
    test_bad_cksum();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
